// File: rtl/dma_engine_if.sv
// Data-bus bundle shared by the CPU and the DMA engine: read/write strobes,
// byte address, write data, read data and the two acknowledges.
interface dma_engine_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        read_acc;
  logic        write_acc;

  modport master (
    output read, write, addr, wdata,
    input  rdata, read_acc, write_acc
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, read_acc, write_acc
  );
endinterface

// File: rtl/dma_engine.sv
// Word-copy DMA master: one bus read then one bus write per word, stopping
// with a sticky error on misalignment, read timeout, rejected write or abort.
module dma_engine #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [31:0]      o_err_addr,
  output logic [LEN_W-1:0] o_remaining,
  dma_engine_if.master     bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_WACK, S_DONE} state_t;

  state_t             r_state,     w_state;
  logic [31:0]        r_src,       w_src;
  logic [31:0]        r_dst,       w_dst;
  logic [31:0]        r_buf,       w_buf;
  logic [WAIT_W-1:0]  r_wait,      w_wait;
  logic [LEN_W-1:0]   r_remaining, w_remaining;
  logic               r_error,     w_error;
  logic [31:0]        r_err_addr,  w_err_addr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_state     = r_state;
    w_src       = r_src;
    w_dst       = r_dst;
    w_buf       = r_buf;
    w_wait      = r_wait;
    w_remaining = r_remaining;
    w_error     = r_error;
    w_err_addr  = r_err_addr;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_src[1:0] != 2'b00) begin
            w_error    = 1'b1;
            w_err_addr = i_src;
          end else if (i_dst[1:0] != 2'b00) begin
            w_error    = 1'b1;
            w_err_addr = i_dst;
          end else begin
            w_error     = 1'b0;
            w_src       = i_src;
            w_dst       = i_dst;
            w_remaining = i_len;
            w_wait      = '0;
            w_state     = (i_len == '0) ? S_DONE : S_RD;
          end
        end
      end

      S_RD: begin
        bus.read = 1'b1;
        bus.addr = r_src;
        if (i_abort) begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end else if (bus.read_acc) begin
          w_buf   = bus.rdata;
          w_wait  = '0;
          w_state = S_WR;
        end else if (r_wait == WAIT_LAST) begin
          w_error    = 1'b1;
          w_err_addr = r_src;
          w_wait     = '0;
          w_state    = S_IDLE;
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end

      // The write strobe is on the bus for this whole cycle even if abort arrives.
      S_WR: begin
        bus.write = 1'b1;
        bus.addr  = r_dst;
        bus.wdata = r_buf;
        if (i_abort) begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_state = S_WACK;
        end
      end

      S_WACK: begin
        if (i_abort) begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end else if (bus.write_acc) begin
          w_remaining = r_remaining - 1'b1;
          w_src       = r_src + 32'd4;
          w_dst       = r_dst + 32'd4;
          w_state     = (r_remaining == LEN_W'(1)) ? S_DONE : S_RD;
        end else begin
          w_error    = 1'b1;
          w_err_addr = r_dst;
          w_state    = S_IDLE;
        end
      end

      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_buf       <= '0;
      r_wait      <= '0;
      r_remaining <= '0;
      r_error     <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_state     <= w_state;
      r_src       <= w_src;
      r_dst       <= w_dst;
      r_buf       <= w_buf;
      r_wait      <= w_wait;
      r_remaining <= w_remaining;
      r_error     <= w_error;
      r_err_addr  <= w_err_addr;
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_error     = r_error;
  assign o_err_addr  = r_err_addr;
  assign o_remaining = r_remaining;

endmodule
